// File: rtl/led_frame_buffer_pkg.sv
// Shared types for the LED frame buffer slice.
// Contents: matrix geometry constants, column/row types, the buffer FSM
// state enum and the masked-merge helper used for byte writes.
package led_pkg;

    localparam int LED_COLS     = 4;
    localparam int LED_ROW_BITS = 8;

    typedef logic [$clog2(LED_COLS)-1:0] col_t;
    typedef logic [LED_ROW_BITS-1:0]     row_t;

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    // Bits set in mask take their value from data; the rest keep old.
    function automatic row_t merge_row(input row_t old_row, input row_t data, input row_t mask);
        return (old_row & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/led_frame_buffer_if.sv
// Producer-side port bundle of the LED frame buffer.
// Signals: wr_valid/wr_ready byte-write handshake with wr_col, wr_data,
// wr_mask; commit and clear single-cycle requests; busy and swap_done status.
// master = the producer, slave = the frame buffer.
interface led_frame_buffer_if;
    import led_pkg::*;

    logic wr_valid;
    logic wr_ready;
    col_t wr_col;
    row_t wr_data;
    row_t wr_mask;
    logic commit;
    logic clear;
    logic busy;
    logic swap_done;

    modport master (
        output wr_valid, wr_col, wr_data, wr_mask, commit, clear,
        input  wr_ready, busy, swap_done
    );

    modport slave (
        input  wr_valid, wr_col, wr_data, wr_mask, commit, clear,
        output wr_ready, busy, swap_done
    );

endinterface

// File: rtl/led_frame_buffer_tick.sv
// Free-running frame-rate divider.
// Ports: clk12MHz (clock), reset (sync, active-high),
// tick (high for one cycle every TICK_DIV cycles, when the count is TICK_DIV-1).
// Usable by any producer that needs a frame-rate strobe.
module led_frame_tick #(
    parameter int TICK_DIV = 12000
) (
    input  logic clk12MHz,
    input  logic reset,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered 4x8 frame store feeding the LED matrix scanner.
// Ports: clk12MHz, reset (sync, active-high); bus (slave side of
// led_frame_buffer_if: byte writes into the back buffer, commit, clear,
// busy, swap_done); frame_count (completed swaps, wraps silently);
// leds1..leds4 (front columns 0..3, bit n = row n+1).
// Writes only ever reach the back buffer; the front buffer is replaced
// wholesale on a frame tick after a commit, so the scanner never sees a
// partially edited frame.
module led_frame_buffer
    import led_pkg::*;
#(
    parameter int TICK_DIV = 12000,
    parameter int FC_W     = 16
) (
    input  logic               clk12MHz,
    input  logic               reset,
    led_frame_buffer_if.slave  bus,
    output logic [FC_W-1:0]    frame_count,
    output row_t               leds1,
    output row_t               leds2,
    output row_t               leds3,
    output row_t               leds4
);
    state_t          r_state;
    state_t          w_next_state;
    row_t            r_back  [LED_COLS];
    row_t            r_front [LED_COLS];
    col_t            r_col_idx;
    logic [FC_W-1:0] r_frame_count;
    logic            r_swap_done;
    logic            w_tick;
    logic            w_wr_fire;

    led_frame_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk12MHz (clk12MHz),
        .reset    (reset),
        .tick     (w_tick)
    );

    // State register.
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            r_state <= ACCEPT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Clear wins over a same-cycle commit; a tick seen in
    // ACCEPT is ignored, so a commit on a tick waits for the following one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ACCEPT: begin
                if (bus.clear) begin
                    w_next_state = CLEAR;
                end else if (bus.commit) begin
                    w_next_state = PENDING;
                end
            end
            PENDING: begin
                if (w_tick) begin
                    w_next_state = ACCEPT;
                end
            end
            CLEAR: begin
                if (r_col_idx == col_t'(LED_COLS - 1)) begin
                    w_next_state = ACCEPT;
                end
            end
            default: w_next_state = ACCEPT;
        endcase
    end

    // Output decode: purely from state, no input reaches wr_ready.
    always_comb begin
        bus.wr_ready = 1'b0;
        bus.busy     = 1'b1;
        if (r_state == ACCEPT) begin
            bus.wr_ready = 1'b1;
            bus.busy     = 1'b0;
        end
    end

    assign w_wr_fire = bus.wr_valid && bus.wr_ready;

    // Buffers, clear sweep, swap and frame counter.
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            // NOTE: the 4x8 store is plain flops, not a RAM, so it is reset
            // like any register; the display must come up dark.
            for (int i = 0; i < LED_COLS; i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
            r_col_idx     <= '0;
            r_frame_count <= '0;
            r_swap_done   <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;

            if (w_wr_fire) begin
                r_back[bus.wr_col] <= merge_row(r_back[bus.wr_col], bus.wr_data, bus.wr_mask);
            end

            case (r_state)
                ACCEPT: begin
                    if (bus.clear) begin
                        r_col_idx <= '0;
                    end
                end
                PENDING: begin
                    if (w_tick) begin
                        for (int i = 0; i < LED_COLS; i++) begin
                            r_front[i] <= r_back[i];
                        end
                        r_frame_count <= r_frame_count + 1'b1;
                        r_swap_done   <= 1'b1;
                    end
                end
                CLEAR: begin
                    // One column per cycle; wr_ready is low, so no write can collide.
                    r_back[r_col_idx] <= '0;
                    r_col_idx         <= r_col_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.swap_done = r_swap_done;
    assign frame_count   = r_frame_count;
    assign leds1         = r_front[0];
    assign leds2         = r_front[1];
    assign leds3         = r_front[2];
    assign leds4         = r_front[3];

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer: each commit pushes the expected
// front image and frame count; a monitor pops and compares on swap_done.
module tb_led_frame_buffer;
    import led_pkg::*;

    localparam int TICK_DIV = 8;
    localparam int FC_W     = 4;

    typedef struct packed {
        logic [31:0]     leds;   // {leds4, leds3, leds2, leds1}
        logic [FC_W-1:0] fc;
    } exp_t;

    logic clk12MHz = 1'b0;
    logic reset    = 1'b1;
    logic [FC_W-1:0] frame_count;
    row_t leds1, leds2, leds3, leds4;

    led_frame_buffer_if bus ();

    led_frame_buffer #(.TICK_DIV(TICK_DIV), .FC_W(FC_W)) dut (
        .clk12MHz    (clk12MHz),
        .reset       (reset),
        .bus         (bus),
        .frame_count (frame_count),
        .leds1       (leds1),
        .leds2       (leds2),
        .leds3       (leds3),
        .leds4       (leds4)
    );

    always #5 clk12MHz = ~clk12MHz;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    row_t m_back[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] leds_now();
        return {leds4, leds3, leds2, leds1};
    endfunction

    // Monitor: every swap_done pulse must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk12MHz);
            if (!reset && bus.swap_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_swap", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("swap_leds", leds_now(), e.leds);
                    check("swap_frame_count", 32'(frame_count), 32'(e.fc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk12MHz);
        #1;
    endtask

    // Present one cycle of producer signals, then return them to idle.
    task automatic drive(input logic v, input col_t c, input row_t d, input row_t m,
                         input logic cm, input logic cl);
        bus.wr_valid = v;
        bus.wr_col   = c;
        bus.wr_data  = d;
        bus.wr_mask  = m;
        bus.commit   = cm;
        bus.clear    = cl;
        step();
        bus.wr_valid = 1'b0;
        bus.commit   = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic expect_swap(input logic [31:0] l, input int fc);
        exp_t e;
        e.leds = l;
        e.fc   = FC_W'(fc);
        sb_q.push_back(e);
    endtask

    // Wait for the swap with a bounded budget; while pending the block must
    // be busy and refuse writes, and swap_done must last one cycle.
    task automatic wait_swap(input string name);
        bit seen = 0;
        for (int i = 0; i < TICK_DIV + 4; i++) begin
            if (bus.swap_done) begin
                seen = 1;
                check({name, "_ready_after"}, 32'(bus.wr_ready), 32'd1);
                break;
            end
            check({name, "_busy_pending"}, {30'd0, bus.busy, bus.wr_ready}, 32'b10);
            step();
        end
        if (!seen) begin
            check({name, "_swap_timeout"}, 32'd0, 32'd1);
        end else begin
            step();
            check({name, "_swap_done_width"}, 32'(bus.swap_done), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        bus.wr_valid = 1'b0;
        bus.wr_col   = '0;
        bus.wr_data  = '0;
        bus.wr_mask  = '0;
        bus.commit   = 1'b0;
        bus.clear    = 1'b0;

        // Reset state.
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_leds", leds_now(), 32'h0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check("rst_status", {29'd0, bus.wr_ready, bus.busy, bus.swap_done}, 32'b100);

        // Write without commit never reaches the display.
        drive(1'b1, 2'd0, 8'hA5, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            check("nocommit_leds", leds_now(), 32'h0);
            check("nocommit_busy", 32'(bus.busy), 32'd0);
            step();
        end

        // Write col2, then commit; back col0 = A5 also goes out.
        drive(1'b1, 2'd2, 8'h3C, 8'hFF, 1'b0, 1'b0);
        expect_swap(32'h003C00A5, 1);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        wait_swap("commit1");

        // Masked write: col1 FF, then data 00 under mask 0F -> F0.
        drive(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 8'h00, 8'h0F, 1'b0, 1'b0);
        expect_swap(32'h003CF0A5, 2);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        wait_swap("masked");

        // Write and commit together, plus an ignored commit while pending.
        expect_swap(32'h813CF0A5, 3);
        drive(1'b1, 2'd3, 8'h81, 8'hFF, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        wait_swap("wr_commit");
        repeat (2 * TICK_DIV) step();
        check("single_swap_fc", 32'(frame_count), 32'd3);

        // Fill back with FF; last write lands with clear+commit, clear wins.
        drive(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 8'hFF, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 8'hFF, 8'hFF, 1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.wr_ready) break;
            check("clear_busy", 32'(bus.busy), 32'd1);
            cnt++;
            step();
        end
        check("clear_len", 32'(cnt), 32'd4);
        repeat (2 * TICK_DIV) step();
        check("clear_no_swap_fc", 32'(frame_count), 32'd3);
        check("clear_no_swap_leds", leds_now(), 32'h813CF0A5);
        expect_swap(32'h00000000, 4);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        wait_swap("after_clear");

        // Reset while pending discards the swap.
        drive(1'b1, 2'd0, 8'h77, 8'hFF, 1'b1, 1'b0);
        check("pre_reset_pending", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("mid_rst_leds", leds_now(), 32'h0);
        check("mid_rst_fc", 32'(frame_count), 32'd0);
        check("mid_rst_ready", {30'd0, bus.wr_ready, bus.busy}, 32'b10);
        repeat (2 * TICK_DIV) step();
        check("mid_rst_no_swap", 32'(frame_count), 32'd0);

        // 17 swaps with FC_W = 4: count wraps to 1. Back was reset to zero.
        for (int i = 0; i < 4; i++) m_back[i] = 8'h00;
        expect_swap(32'h00000000, 1);
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        wait_swap("wrap0");
        for (int k = 1; k < 17; k++) begin
            row_t d;
            d = row_t'(k * 37);
            m_back[k % 4] = d;
            expect_swap({m_back[3], m_back[2], m_back[1], m_back[0]}, (k + 1) % 16);
            drive(1'b1, col_t'(k % 4), d, 8'hFF, 1'b1, 1'b0);
            wait_swap("wrap");
        end
        check("wrap_fc", 32'(frame_count), 32'd1);

        repeat (4) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
